reg_bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one register/memory bus (testRegBlock-style ADDR/WE/RE/DATA_WR/WSTRB → DATA_RD/READY) between NUM_REQ requesters.
- Each requester posts a single read or write command and holds it until acknowledged.
- The arbiter serialises commands, drives the bus strobes and waits for READY.
- It returns read data or an error to the winning requester.

---
 rtl/reg_bus_arb_pkg.sv | 6 +
 rtl/reg_bus_arbiter_rr_pick.sv | 18 +
 rtl/reg_bus_arbiter.sv | 113 +++++++++++
 tb/tb_reg_bus_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bus_arb_pkg.sv
// reg_bus_arb_pkg: shared state type and constants for reg_bus_arbiter
package reg_bus_arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   localparam logic [1:0] ALIGN_MASK = 2'b11;
   localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/reg_bus_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority picker, first set bit at or after ptr
module rr_pick #(
   parameter int N = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] winner
);
   always_comb begin
      valid = |req;
      winner = '0;
      // scan from the farthest offset down so the nearest set bit wins
      for (int i = N - 1; i >= 0; i--)
         if (req[(int'(ptr) + i) % N]) winner = IW'((int'(ptr) + i) % N);
   end
endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: round-robin sequencer sharing one register bus among NUM_REQ requesters.
// Define REG_BUS_ARB_TIMEOUT_EN to abort bus cycles that see no bus_ready within TIMEOUT cycles.
module reg_bus_arbiter
   import reg_bus_arb_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int SW = 4,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ-1:0]    req_we,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*DW-1:0] req_wdata,
   input  logic [NUM_REQ*SW-1:0] req_wstrb,
   output logic [NUM_REQ-1:0]    ack,
   output logic [DW-1:0]         rsp_rdata,
   output logic                  rsp_err,
   output logic [AW-1:0]         bus_addr,
   output logic                  bus_we,
   output logic                  bus_re,
   output logic [DW-1:0]         bus_wdata,
   output logic [SW-1:0]         bus_wstrb,
   input  logic [DW-1:0]         bus_rdata,
   input  logic                  bus_ready
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   state_t state;
   logic [IW-1:0] rr_ptr, win_idx, pick;
   logic pick_valid;
   logic [AW-1:0] sel_addr;
   assign sel_addr = req_addr[int'(pick)*AW +: AW];
   rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
      .req(req),
      .ptr(rr_ptr),
      .valid(pick_valid),
      .winner(pick)
   );
`ifdef REG_BUS_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   logic expired;
   assign expired = cnt == CW'(TIMEOUT - 1);
`endif
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
         rr_ptr <= '0;
         win_idx <= '0;
         ack <= '0;
         rsp_rdata <= '0;
         rsp_err <= 1'b0;
         bus_addr <= '0;
         bus_we <= 1'b0;
         bus_re <= 1'b0;
         bus_wdata <= '0;
         bus_wstrb <= '0;
`ifdef REG_BUS_ARB_TIMEOUT_EN
         cnt <= '0;
`endif
      end else begin
         ack <= '0;
         case (state)
            IDLE: if (pick_valid) begin
               win_idx <= pick;
               bus_addr <= sel_addr;
               bus_wdata <= req_wdata[int'(pick)*DW +: DW];
               bus_wstrb <= req_wstrb[int'(pick)*SW +: SW];
               if ((sel_addr[1:0] & ALIGN_MASK) != 2'b00) begin
                  state <= RESP;
                  ack <= NUM_REQ'(1) << pick;
                  rsp_err <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
                  state <= BUSY;
                  bus_we <= req_we[pick];
                  bus_re <= !req_we[pick];
`ifdef REG_BUS_ARB_TIMEOUT_EN
                  cnt <= '0;
`endif
               end
            end
            BUSY: if (bus_ready) begin
               state <= RESP;
               ack <= NUM_REQ'(1) << win_idx;
               rsp_err <= 1'b0;
               rsp_rdata <= bus_we ? '0 : bus_rdata;
               bus_we <= 1'b0;
               bus_re <= 1'b0;
`ifdef REG_BUS_ARB_TIMEOUT_EN
            end else if (expired) begin
               state <= RESP;
               ack <= NUM_REQ'(1) << win_idx;
               rsp_err <= 1'b1;
               rsp_rdata <= '0;
               bus_we <= 1'b0;
               bus_re <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
`endif
            end
            RESP: begin
               state <= IDLE;
               rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed and randomized checks of reg_bus_arbiter against a rotating-priority model
module tb_reg_bus_arbiter;
   localparam int N = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;
   logic clk = 1'b0;
   logic rst_b = 1'b0;
   logic [N-1:0] req, req_we, ack;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N*SW-1:0] req_wstrb;
   logic [DW-1:0] rsp_rdata, bus_wdata, bus_rdata;
   logic rsp_err, bus_we, bus_re, bus_ready;
   logic [AW-1:0] bus_addr;
   logic [SW-1:0] bus_wstrb;
   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   reg_bus_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .SW(SW), .TIMEOUT(16)) dut (
      .clk(clk), .rst_b(rst_b), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wstrb(req_wstrb), .ack(ack), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .bus_addr(bus_addr), .bus_we(bus_we), .bus_re(bus_re),
      .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rdata(bus_rdata), .bus_ready(bus_ready)
   );

   task automatic set_cmd(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
      req_we[i] = we;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
      req_wstrb[i*SW +: SW] = s;
   endtask

   task automatic test_reset;
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      bus_ready = 1'b0; bus_rdata = '0;
      rst_b = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({ack, rsp_rdata, rsp_err, bus_addr, bus_we, bus_re, bus_wdata, bus_wstrb} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got ack=%b rdata=%h err=%b addr=%h we=%b re=%b wdata=%h wstrb=%h, required all 0",
                  ack, rsp_rdata, rsp_err, bus_addr, bus_we, bus_re, bus_wdata, bus_wstrb);
      end
      rst_b = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({ack, bus_we, bus_re} !== '0) begin
         miscompares++;
         $display("FAIL idle_no_req: got ack=%b we=%b re=%b, required 0", ack, bus_we, bus_re);
      end
   endtask

   task automatic test_write;
      set_cmd(0, 1'b1, 32'h0, 32'h12345678, 4'hF);
      req = 3'b001; bus_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus_we, bus_re, bus_addr, bus_wdata, bus_wstrb, ack} !== {1'b1, 1'b0, 32'h0, 32'h12345678, 4'hF, 3'b000}) begin
         miscompares++;
         $display("FAIL write_bus: got we=%b re=%b addr=%h wdata=%h wstrb=%h ack=%b, required 1 0 0 12345678 f 000",
                  bus_we, bus_re, bus_addr, bus_wdata, bus_wstrb, ack);
      end
      @(negedge clk);
      vectors++;
      if (ack !== 3'b001 || rsp_err !== 1'b0 || rsp_rdata !== '0 || bus_we !== 1'b0) begin
         miscompares++;
         $display("FAIL write_ack: got ack=%b err=%b rdata=%h we=%b, required 001 0 0 0", ack, rsp_err, rsp_rdata, bus_we);
      end
      req = '0; bus_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (ack !== '0) begin
         miscompares++;
         $display("FAIL write_ack_pulse: got ack=%b, required 000", ack);
      end
   endtask

   task automatic test_read_wait;
      set_cmd(1, 1'b0, 32'h8, 32'h0, 4'h0);
      req = 3'b010; bus_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         vectors++;
         if (bus_re !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h8 || ack !== '0) begin
            miscompares++;
            $display("FAIL read_wait_%0d: got re=%b we=%b addr=%h ack=%b, required 1 0 8 000", i, bus_re, bus_we, bus_addr, ack);
         end
         if (i == 3) begin bus_ready = 1'b1; bus_rdata = 32'h87654321; end
      end
      @(negedge clk);
      vectors++;
      if (ack !== 3'b010 || rsp_rdata !== 32'h87654321 || rsp_err !== 1'b0 || bus_re !== 1'b0) begin
         miscompares++;
         $display("FAIL read_ack: got ack=%b rdata=%h err=%b re=%b, required 010 87654321 0 0", ack, rsp_rdata, rsp_err, bus_re);
      end
      req = '0; bus_ready = 1'b0; bus_rdata = '0;
      @(negedge clk);
   endtask

   task automatic test_contention;
      logic [N-1:0] exp_ack;
      rst_b = 1'b0;
      set_cmd(0, 1'b0, 32'h0, 32'h0, 4'h0);
      set_cmd(1, 1'b0, 32'h4, 32'h0, 4'h0);
      req = 3'b011; bus_ready = 1'b1; bus_rdata = 32'hA5A5_0000;
      @(negedge clk);
      rst_b = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         exp_ack = '0;
         if (c % 3 == 2) exp_ack[((c - 2) / 3) % 2] = 1'b1;
         vectors++;
         if (ack !== exp_ack) begin
            miscompares++;
            $display("FAIL contention_cycle_%0d: got ack=%b, required %b", c, ack, exp_ack);
         end
      end
      req = '0; bus_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_misaligned;
      set_cmd(0, 1'b1, 32'h22, 32'hCAFE, 4'hF);
      req = 3'b001; bus_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (ack !== 3'b001 || rsp_err !== 1'b1 || bus_we !== 1'b0 || bus_re !== 1'b0) begin
         miscompares++;
         $display("FAIL misaligned_ack: got ack=%b err=%b we=%b re=%b, required 001 1 0 0", ack, rsp_err, bus_we, bus_re);
      end
      req = '0; bus_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (ack !== '0 || rsp_err !== 1'b1 || bus_we !== 1'b0 || bus_re !== 1'b0) begin
         miscompares++;
         $display("FAIL misaligned_hold: got ack=%b err=%b we=%b re=%b, required 000 1 0 0", ack, rsp_err, bus_we, bus_re);
      end
   endtask

   task automatic test_timeout;
      int hi = 0;
      int got = -1;
      set_cmd(1, 1'b0, 32'h4, 32'h0, 4'h0);
      req = 3'b010; bus_ready = 1'b0; bus_rdata = 32'hDEADBEEF;
      for (int c = 1; c <= 100 && got < 0; c++) begin
         @(negedge clk);
         if (bus_re) hi++;
         if (ack !== '0) got = c;
      end
`ifdef REG_BUS_ARB_TIMEOUT_EN
      vectors++;
      if (got != 17 || hi != 16) begin
         miscompares++;
         $display("FAIL timeout_timing: got ack at cycle %0d with strobe %0d cycles, required 17 and 16", got, hi);
      end
      vectors++;
      if (ack !== 3'b010 || rsp_err !== 1'b1 || rsp_rdata !== '0) begin
         miscompares++;
         $display("FAIL timeout_rsp: got ack=%b err=%b rdata=%h, required 010 1 0", ack, rsp_err, rsp_rdata);
      end
      req = '0;
`else
      vectors++;
      if (got >= 0 || hi != 100) begin
         miscompares++;
         $display("FAIL no_timeout: got ack at cycle %0d with strobe %0d cycles, required none and 100", got, hi);
      end
      bus_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (ack !== 3'b010 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL late_ready: got ack=%b err=%b rdata=%h, required 010 0 deadbeef", ack, rsp_err, rsp_rdata);
      end
      req = '0; bus_ready = 1'b0;
`endif
      @(negedge clk);
   endtask

   task automatic test_reset_mid;
      set_cmd(0, 1'b1, 32'h10, 32'h1111, 4'h3);
      req = 3'b001; bus_ready = 1'b0;
      @(negedge clk);
      vectors++;
      if (bus_we !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_start: got we=%b, required 1", bus_we);
      end
      #2 rst_b = 1'b0;
      #1;
      vectors++;
      if (bus_we !== 1'b0 || bus_re !== 1'b0 || ack !== '0 || bus_addr !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_abort: got we=%b re=%b ack=%b addr=%h, required 0 0 000 0", bus_we, bus_re, ack, bus_addr);
      end
      set_cmd(1, 1'b0, 32'h30, 32'h0, 4'h0);
      req = 3'b010;
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      vectors++;
      if (bus_re !== 1'b1 || bus_addr !== 32'h30 || ack !== '0) begin
         miscompares++;
         $display("FAIL reset_mid_grant: got re=%b addr=%h ack=%b, required 1 30 000", bus_re, bus_addr, ack);
      end
      bus_ready = 1'b1; bus_rdata = 32'h5A5A5A5A;
      @(negedge clk);
      vectors++;
      if (ack !== 3'b010 || rsp_rdata !== 32'h5A5A5A5A) begin
         miscompares++;
         $display("FAIL reset_mid_ack: got ack=%b rdata=%h, required 010 5a5a5a5a", ack, rsp_rdata);
      end
      req = '0; bus_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random;
      logic [N-1:0] pend, mwe, oh;
      logic [AW-1:0] maddr [N];
      logic [DW-1:0] mwd [N];
      logic [SW-1:0] mws [N];
      logic [DW-1:0] rd;
      int ptr, exp, wait_cnt;
      logic found;
      rst_b = 1'b0; req = '0; bus_ready = 1'b0;
      @(negedge clk);
      rst_b = 1'b1;
      ptr = 0; rd = '0;
      for (int b = 0; b < 40; b++) begin
         pend = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            mwe[i] = 1'($urandom_range(0, 1));
            maddr[i] = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 4) == 0) maddr[i][1:0] = 2'($urandom_range(1, 3));
            mwd[i] = $urandom;
            mws[i] = SW'($urandom);
            set_cmd(i, mwe[i], maddr[i], mwd[i], mws[i]);
         end
         req = pend;
         wait_cnt = -1;
         for (int c = 0; c < 200 && pend != '0; c++) begin
            @(negedge clk);
            exp = 0; found = 1'b0;
            for (int k = 0; k < N; k++)
               if (!found && pend[(ptr + k) % N]) begin exp = (ptr + k) % N; found = 1'b1; end
            if (ack !== '0) begin
               oh = '0; oh[exp] = 1'b1;
               vectors++;
               if (ack !== oh || rsp_err !== (maddr[exp][1:0] != 2'b00) ||
                   (maddr[exp][1:0] == 2'b00 && rsp_rdata !== (mwe[exp] ? '0 : rd))) begin
                  miscompares++;
                  $display("FAIL random_ack b%0d: got ack=%b err=%b rdata=%h, required ack=%b err=%b rdata=%h",
                           b, ack, rsp_err, rsp_rdata, oh, maddr[exp][1:0] != 2'b00, mwe[exp] ? '0 : rd);
               end
               pend[exp] = 1'b0; req[exp] = 1'b0;
               ptr = (exp + 1) % N;
            end
            if (bus_we || bus_re) begin
               vectors++;
               if (maddr[exp][1:0] != 2'b00 || bus_we !== mwe[exp] || bus_re !== !mwe[exp] ||
                   bus_addr !== maddr[exp] || bus_wdata !== mwd[exp] || bus_wstrb !== mws[exp]) begin
                  miscompares++;
                  $display("FAIL random_bus b%0d: got we=%b re=%b addr=%h wdata=%h wstrb=%h, required requester %0d we=%b addr=%h wdata=%h wstrb=%h",
                           b, bus_we, bus_re, bus_addr, bus_wdata, bus_wstrb, exp, mwe[exp], maddr[exp], mwd[exp], mws[exp]);
               end
               if (wait_cnt < 0) wait_cnt = $urandom_range(0, 3);
               if (wait_cnt == 0) begin
                  rd = $urandom; bus_rdata = rd; bus_ready = 1'b1; wait_cnt = -1;
               end else begin
                  wait_cnt--; bus_ready = 1'b0; bus_rdata = $urandom;
               end
            end else begin
               bus_ready = 1'($urandom_range(0, 1));
               bus_rdata = $urandom;
            end
         end
         vectors++;
         if (pend != '0) begin
            miscompares++;
            $display("FAIL random_drain b%0d: got pending=%b after 200 cycles, required 000", b, pend);
         end
         req = '0; bus_ready = 1'b0;
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset;
      test_write;
      test_read_wait;
      test_contention;
      test_misaligned;
      test_timeout;
      test_reset_mid;
      test_random;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
